// File: rtl/codec_i2c_arbiter.sv
// codec_i2c_arbiter
// Shares one codec i2c_controller between NUM_REQ requesters (init sequencer,
// runtime control, debug port). Round-robin arbitration, one register/data write
// per grant. Owns the controller enable, which the controller uses as its reset:
// enable is high only for the duration of a transfer and low for at least
// GAP_CYCLES cycles between transfers. A watchdog aborts transfers that run for
// TIMEOUT_CYCLES cycles and reports error code 4'hF.
//
// Optional feature macro: RETRY_ON_ERROR_EN
//   When defined, a transfer that completes with a nonzero controller error is
//   retried once (the grant is held, no ack) and the second result is acked.
//   Timeouts are never retried.
//
// Ports
//   clk, rst       clock, synchronous active-high reset
//   req            per-requester request level, held until ack
//   req_register   7-bit register field per requester, slice i = [7*i +: 7]
//   req_data       9-bit data field per requester, slice i = [9*i +: 9]
//   grant          one-hot owner of the current transfer
//   ack            one-cycle pulse to the owner when its transfer ends
//   ack_error      result code, valid in the ack cycle, held until next ack
//   busy           high whenever the arbiter is not idle
//   i2c_en         controller enable (controller reset pin)
//   i2c_register   register field to controller
//   i2c_data       data field to controller
//   i2c_done       controller done level
//   i2c_error      controller error code
module codec_i2c_arbiter #(
  parameter int unsigned NUM_REQ        = 3,
  parameter int unsigned TIMEOUT_CYCLES = 200000,
  parameter int unsigned GAP_CYCLES     = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [7*NUM_REQ-1:0] req_register,
  input  logic [9*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   grant,
  output logic [NUM_REQ-1:0]   ack,
  output logic [3:0]           ack_error,
  output logic                 busy,
  output logic                 i2c_en,
  output logic [6:0]           i2c_register,
  output logic [8:0]           i2c_data,
  input  logic                 i2c_done,
  input  logic [3:0]           i2c_error
);

  localparam int unsigned PtrW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CntMax = (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES;
  localparam int unsigned CntW   = $clog2(CntMax + 1);
  localparam logic [CntW-1:0] TimeoutLast = CntW'(TIMEOUT_CYCLES - 1);
  localparam logic [CntW-1:0] GapLast     = CntW'(GAP_CYCLES - 1);
  localparam logic [PtrW-1:0] LastReq     = PtrW'(NUM_REQ - 1);

  typedef enum logic [2:0] {StIdle, StLoad, StRun, StAck, StGap} state_e;

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [PtrW-1:0]    owner_q, owner_d;
  logic [PtrW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [3:0]         ack_error_q, ack_error_d;
  logic               i2c_en_q, i2c_en_d;
  logic [6:0]         register_q, register_d;
  logic [8:0]         data_q, data_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
`ifdef RETRY_ON_ERROR_EN
  logic               retried_q, retried_d;
`endif

  logic               pick_valid;
  logic [PtrW-1:0]    pick;
  logic [NUM_REQ-1:0] pick_onehot;
  logic [6:0]         pick_register;
  logic [8:0]         pick_data;

  // First active requester at or after rr_ptr, searching upward with wrap.
  always_comb begin
    pick_valid = 1'b0;
    pick       = '0;
    for (int k = 0; k < int'(NUM_REQ); k++) begin
      for (int i = 0; i < int'(NUM_REQ); i++) begin
        if (!pick_valid && req[i] && (i == (int'(rr_ptr_q) + k) % int'(NUM_REQ))) begin
          pick_valid = 1'b1;
          pick       = PtrW'(i);
        end
      end
    end
  end

  always_comb begin
    pick_onehot   = '0;
    pick_register = '0;
    pick_data     = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (pick == PtrW'(i)) begin
        pick_onehot[i] = 1'b1;
        pick_register  = req_register[7*i +: 7];
        pick_data      = req_data[9*i +: 9];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    owner_d     = owner_q;
    rr_ptr_d    = rr_ptr_q;
    ack_error_d = ack_error_q;
    i2c_en_d    = i2c_en_q;
    register_d  = register_q;
    data_d      = data_q;
    cnt_d       = cnt_q;
`ifdef RETRY_ON_ERROR_EN
    retried_d   = retried_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (pick_valid) begin
          register_d = pick_register;
          data_d     = pick_data;
          grant_d    = pick_onehot;
          owner_d    = pick;
`ifdef RETRY_ON_ERROR_EN
          retried_d  = 1'b0;
`endif
          state_d    = StLoad;
        end
      end
      StLoad: begin
        i2c_en_d = 1'b1;
        cnt_d    = '0;
        state_d  = StRun;
      end
      StRun: begin
        cnt_d = cnt_q + CntW'(1);
        // done has priority over the watchdog when both hit in one cycle
        if (i2c_done) begin
`ifdef RETRY_ON_ERROR_EN
          if ((i2c_error != 4'h0) && !retried_q) begin
            retried_d = 1'b1;
            i2c_en_d  = 1'b0;
            cnt_d     = '0;
            state_d   = StGap;
          end else begin
            ack_error_d = i2c_error;
            state_d     = StAck;
          end
`else
          ack_error_d = i2c_error;
          state_d     = StAck;
`endif
        end else if (cnt_q == TimeoutLast) begin
          ack_error_d = 4'hF;
          state_d     = StAck;
        end
      end
      StAck: begin
        i2c_en_d = 1'b0;
        grant_d  = '0;
        rr_ptr_d = (owner_q == LastReq) ? '0 : owner_q + PtrW'(1);
        cnt_d    = '0;
        state_d  = StGap;
      end
      StGap: begin
        if (cnt_q == GapLast) begin
          cnt_d   = '0;
          // grant is still held only when this gap precedes a retry
          state_d = (|grant_q) ? StLoad : StIdle;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      grant_q     <= '0;
      owner_q     <= '0;
      rr_ptr_q    <= '0;
      ack_error_q <= '0;
      i2c_en_q    <= 1'b0;
      register_q  <= '0;
      data_q      <= '0;
      cnt_q       <= '0;
`ifdef RETRY_ON_ERROR_EN
      retried_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      owner_q     <= owner_d;
      rr_ptr_q    <= rr_ptr_d;
      ack_error_q <= ack_error_d;
      i2c_en_q    <= i2c_en_d;
      register_q  <= register_d;
      data_q      <= data_d;
      cnt_q       <= cnt_d;
`ifdef RETRY_ON_ERROR_EN
      retried_q   <= retried_d;
`endif
    end
  end

  assign grant        = grant_q;
  assign ack          = (state_q == StAck) ? grant_q : '0;
  assign ack_error    = ack_error_q;
  assign busy         = (state_q != StIdle);
  assign i2c_en       = i2c_en_q;
  assign i2c_register = register_q;
  assign i2c_data     = data_q;

endmodule

// File: tb/tb_codec_i2c_arbiter.sv
// Testbench for codec_i2c_arbiter. Requesters and a behavioural i2c controller
// are modelled here; expected owner, fields, enable windows, ack and error code
// are derived from the round-robin rule and the controller's chosen latency.
module tb_codec_i2c_arbiter;

  localparam int N   = 3;
  localparam int TO  = 32;
  localparam int GAP = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [7*N-1:0] req_register;
  logic [9*N-1:0] req_data;
  logic [N-1:0]   grant;
  logic [N-1:0]   ack;
  logic [3:0]     ack_error;
  logic           busy;
  logic           i2c_en;
  logic [6:0]     i2c_register;
  logic [8:0]     i2c_data;
  logic           i2c_done = 1'b0;
  logic [3:0]     i2c_error = 4'h0;

  always #5 clk = ~clk;

  codec_i2c_arbiter #(
    .NUM_REQ       (N),
    .TIMEOUT_CYCLES(TO),
    .GAP_CYCLES    (GAP)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .req_register(req_register),
    .req_data    (req_data),
    .grant       (grant),
    .ack         (ack),
    .ack_error   (ack_error),
    .busy        (busy),
    .i2c_en      (i2c_en),
    .i2c_register(i2c_register),
    .i2c_data    (i2c_data),
    .i2c_done    (i2c_done),
    .i2c_error   (i2c_error)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Controller model: done rises after win_len enable cycles, held until enable drops.
  int plan_len[$];
  int plan_err[$];
  int log_len[$];
  int log_err[$];
  int en_cnt  = 0;
  int win_len = 0;
  int win_err = 0;

  always @(negedge clk) begin
    if (!i2c_en) begin
      en_cnt    = 0;
      i2c_done  = 1'b0;
      i2c_error = 4'h0;
    end else begin
      if (en_cnt == 0) begin
        if (plan_len.size() > 0) begin
          win_len = plan_len.pop_front();
          win_err = plan_err.pop_front();
        end else begin
          win_len = ($urandom_range(0, 5) == 0) ? int'($urandom_range(30, 40))
                                                : int'($urandom_range(1, 20));
          win_err = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 15));
        end
        log_len.push_back(win_len);
        log_err.push_back(win_err);
      end
      en_cnt++;
      if (en_cnt >= win_len) begin
        i2c_done  = 1'b1;
        i2c_error = 4'(win_err);
      end
    end
  end

  int model_ptr = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic serve_one();
    int         owner;
    int         en_run;
    int         acks;
    int         gap_cnt;
    int         obs_en[$];
    int         exp_en[$];
    bit         seen;
    logic [N-1:0] got_ack;
    logic [3:0] got_err;
    logic [3:0] exp_err;
    logic [8:0] got_data;
    logic [6:0] exp_reg;
    logic [8:0] exp_data;

    owner = -1;
    for (int k = 0; k < N; k++) begin
      if (owner < 0 && req[(model_ptr + k) % N]) owner = (model_ptr + k) % N;
    end
    if (owner < 0) return;
    exp_reg  = req_register[7*owner +: 7];
    exp_data = req_data[9*owner +: 9];
    log_len.delete();
    log_err.delete();

    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      tick();
      if (grant != '0) seen = 1'b1;
    end
    check_eq("grant_seen", 32'(seen), 32'd1);
    if (!seen) begin
      req = '0;
      plan_len.delete();
      plan_err.delete();
      return;
    end
    check_eq("grant", 32'(grant), 32'(1 << owner));
    check_eq("busy", 32'(busy), 32'd1);
    check_eq("en_before_load", 32'(i2c_en), 32'd0);
    check_eq("reg_field", 32'(i2c_register), 32'(exp_reg));
    check_eq("data_field", 32'(i2c_data), 32'(exp_data));
    tick();
    check_eq("en_latency", 32'(i2c_en), 32'd1);
    // owner rewrites its fields mid-transfer; the controller must not follow
    req_register[7*owner +: 7] = 7'($urandom);
    req_data[9*owner +: 9]     = 9'($urandom);

    en_run   = i2c_en ? 1 : 0;
    acks     = 0;
    gap_cnt  = 0;
    got_ack  = '0;
    got_err  = '0;
    got_data = '0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      tick();
      if (i2c_en) en_run++;
      else if (en_run > 0) begin
        obs_en.push_back(en_run);
        en_run = 0;
      end
      if (ack != '0) begin
        acks++;
        got_ack    = ack;
        got_err    = ack_error;
        got_data   = i2c_data;
        req[owner] = 1'b0;
      end else if (acks > 0 && busy && !i2c_en) begin
        gap_cnt++;
      end
      if (acks > 0 && !busy) break;
    end

    exp_err = 4'hF;
    if (log_len.size() > 0) begin
      if (log_len[0] > TO) begin
        exp_en.push_back(TO + 1);
      end
`ifdef RETRY_ON_ERROR_EN
      else if (log_err[0] != 0) begin
        exp_en.push_back(log_len[0]);
        if (log_len.size() > 1) begin
          if (log_len[1] > TO) exp_en.push_back(TO + 1);
          else begin
            exp_en.push_back(log_len[1] + 1);
            exp_err = 4'(log_err[1]);
          end
        end
      end
`endif
      else begin
        exp_en.push_back(log_len[0] + 1);
        exp_err = 4'(log_err[0]);
      end
    end

    check_eq("ack_count", 32'(acks), 32'd1);
    check_eq("ack_owner", 32'(got_ack), 32'(1 << owner));
    check_eq("ack_error", 32'(got_err), 32'(exp_err));
    check_eq("data_stable", 32'(got_data), 32'(exp_data));
    check_eq("windows", 32'(obs_en.size()), 32'(exp_en.size()));
    for (int w = 0; w < exp_en.size() && w < obs_en.size(); w++) begin
      check_eq("en_window", 32'(obs_en[w]), 32'(exp_en[w]));
    end
    check_eq("gap_len", 32'(gap_cnt), 32'(GAP));
    check_eq("err_hold", 32'(ack_error), 32'(exp_err));
    check_eq("grant_idle", 32'(grant), 32'd0);
    model_ptr = (owner + 1) % N;
    plan_len.delete();
    plan_err.delete();
  endtask

  task automatic run_round(input logic [N-1:0] mask);
    for (int i = 0; i < N; i++) begin
      if (mask[i]) begin
        req_register[7*i +: 7] = 7'($urandom);
        req_data[9*i +: 9]     = 9'($urandom);
      end
    end
    req = mask;
    for (int t = 0; t < N && req != '0; t++) serve_one();
    req = '0;
    for (int c = 0; c < 200 && busy; c++) tick();
  endtask

  initial begin
    int  rst_acks;
    bit  seen;

    rst          = 1'b1;
    req          = '0;
    req_register = '0;
    req_data     = '0;
    repeat (3) tick();
    check_eq("rst_grant", 32'(grant), 32'd0);
    check_eq("rst_ack", 32'(ack), 32'd0);
    check_eq("rst_ack_error", 32'(ack_error), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_en", 32'(i2c_en), 32'd0);
    check_eq("rst_register", 32'(i2c_register), 32'd0);
    check_eq("rst_data", 32'(i2c_data), 32'd0);
    rst = 1'b0;
    tick();

    run_round(3'b111);

    // single request with known fields
    req_register[6:0] = 7'h06;
    req_data[8:0]     = 9'h010;
    plan_len.push_back(20);
    plan_err.push_back(0);
    req = 3'b001;
    serve_one();
    tick();

    run_round(3'b010);
    run_round(3'b011);

    // watchdog: controller never finishes within the limit
    plan_len.push_back(40);
    plan_err.push_back(0);
    req = 3'b001;
    serve_one();
    tick();

    // error on first attempt, clean second attempt
    plan_len.push_back(5);
    plan_err.push_back(2);
    plan_len.push_back(5);
    plan_err.push_back(0);
    req = 3'b100;
    serve_one();
    tick();

    // reset in the middle of a transfer
    plan_len.push_back(1000);
    plan_err.push_back(0);
    req_register[13:7] = 7'h2A;
    req_data[17:9]     = 9'h155;
    req      = 3'b010;
    rst_acks = 0;
    seen     = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      tick();
      if (grant != '0) seen = 1'b1;
    end
    check_eq("rst_run_grant_seen", 32'(seen), 32'd1);
    for (int c = 0; c < 10; c++) begin
      tick();
      if (ack != '0) rst_acks++;
    end
    rst = 1'b1;
    tick();
    check_eq("rst_run_en", 32'(i2c_en), 32'd0);
    check_eq("rst_run_grant", 32'(grant), 32'd0);
    check_eq("rst_run_busy", 32'(busy), 32'd0);
    if (ack != '0) rst_acks++;
    rst = 1'b0;
    req = '0;
    plan_len.delete();
    plan_err.delete();
    model_ptr = 0;
    tick();
    if (ack != '0) rst_acks++;
    check_eq("rst_run_no_ack", 32'(rst_acks), 32'd0);
    run_round(3'b101);

    for (int r = 0; r < 40; r++) begin
      run_round(N'($urandom_range(1, 7)));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
